// File: rtl/sdram_stream_pkg.sv
// Shared types and default sizes for the SDRAM read/write streaming muxes.
package sdram_stream_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 19;
  localparam int LEN_W      = 12;
  localparam int FIFO_DEPTH = 8;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Identifies which client owns the current burst.
  typedef enum logic {
    CLIENT_A,
    CLIENT_B
  } client_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int    WIDTH = 16,
  parameter int    DEPTH = 8,
  localparam int   PTR_W = $clog2(DEPTH),
  localparam int   CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  // NOTE: the array has no reset; its contents are meaningless until written and
  // empty-gating of pop_data keeps stale entries off the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-2 depth.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_streaming_sdram_read.sv
// Two-client burst-read front end for the single SDRAM controller read port.
// Requests are captured into one-entry slots, arbitrated round-robin, issued
// under a credit limit equal to the return FIFO depth, and the returned words
// are streamed to the owning client through the FIFO.
module data_streaming_sdram_read
  import sdram_stream_pkg::*;
#(
  parameter int DATA_W     = sdram_stream_pkg::DATA_W,
  parameter int ADDR_W     = sdram_stream_pkg::ADDR_W,
  parameter int LEN_W      = sdram_stream_pkg::LEN_W,
  parameter int FIFO_DEPTH = sdram_stream_pkg::FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_startA,
  input  logic [ADDR_W-1:0] i_addrA,
  input  logic [LEN_W-1:0]  i_lenA,
  input  logic              i_startB,
  input  logic [ADDR_W-1:0] i_addrB,
  input  logic [LEN_W-1:0]  i_lenB,
  output logic              o_busyA,
  output logic              o_busyB,
  output logic              o_doneA,
  output logic              o_doneB,
  output logic [DATA_W-1:0] o_data,
  output logic              o_validA,
  output logic              o_validB,
  input  logic              i_readyA,
  input  logic              i_readyB,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_enableRead,
  input  logic              i_sdramReady,
  input  logic [DATA_W-1:0] i_readData,
  input  logic              i_readValid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  client_t           grant;
  client_t           last_tie;
  logic              pend_a, pend_b;
  logic [ADDR_W-1:0] slot_addr_a, slot_addr_b;
  logic [LEN_W-1:0]  slot_len_a, slot_len_b;
  logic              take_a, take_b, tie;
  logic [LEN_W-1:0]  next_len;
  logic [LEN_W-1:0]  iss_rem;
  logic [LEN_W-1:0]  pop_rem;
  logic [CNT_W-1:0]  credits;
  logic              active, accept, pop, push;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_data;

  assign active       = (state == ISSUE) || (state == DRAIN);
  assign o_enableRead = (state == ISSUE) && (credits < CNT_W'(FIFO_DEPTH)) && (iss_rem != '0);
  assign accept       = o_enableRead && i_sdramReady;
  assign o_validA     = !fifo_empty && active && (grant == CLIENT_A);
  assign o_validB     = !fifo_empty && active && (grant == CLIENT_B);
  assign o_data       = fifo_data;
  assign pop          = (o_validA && i_readyA) || (o_validB && i_readyB);
  // Only words still owed to the burst are stored; stale returns are dropped.
  assign push         = i_readValid && (fifo_count < credits) && (!fifo_full || pop);

  // Capture slots: a start is taken only while that client is not busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      o_busyA     <= 1'b0;
      o_busyB     <= 1'b0;
      slot_addr_a <= '0;
      slot_addr_b <= '0;
      slot_len_a  <= '0;
      slot_len_b  <= '0;
    end else begin
      if (i_startA && !o_busyA) begin
        pend_a      <= 1'b1;
        o_busyA     <= 1'b1;
        slot_addr_a <= i_addrA;
        slot_len_a  <= i_lenA;
      end else begin
        if (take_a) pend_a <= 1'b0;
        if (state == DONE && grant == CLIENT_A) o_busyA <= 1'b0;
      end
      if (i_startB && !o_busyB) begin
        pend_b      <= 1'b1;
        o_busyB     <= 1'b1;
        slot_addr_b <= i_addrB;
        slot_len_b  <= i_lenB;
      end else begin
        if (take_b) pend_b <= 1'b0;
        if (state == DONE && grant == CLIENT_B) o_busyB <= 1'b0;
      end
    end
  end

  // Round-robin arbiter: last_tie remembers who won the previous tie, so
  // simultaneous requests alternate while a lone request is always served.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    tie    = pend_a && pend_b;
    if (state == IDLE) begin
      if (tie) begin
        take_a = (last_tie == CLIENT_B);
        take_b = (last_tie == CLIENT_A);
      end else begin
        take_a = pend_a;
        take_b = pend_b;
      end
    end
    next_len = take_a ? slot_len_a : slot_len_b;
  end

  // Burst sequencer: grant, issue addresses, wait for delivery, pulse done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      grant    <= CLIENT_A;
      last_tie <= CLIENT_B;
      o_addr   <= '0;
      iss_rem  <= '0;
      pop_rem  <= '0;
      o_doneA  <= 1'b0;
      o_doneB  <= 1'b0;
    end else begin
      o_doneA <= 1'b0;
      o_doneB <= 1'b0;
      if (pop) pop_rem <= pop_rem - 1'b1;
      case (state)
        IDLE: begin
          if (take_a || take_b) begin
            grant   <= take_a ? CLIENT_A : CLIENT_B;
            o_addr  <= take_a ? slot_addr_a : slot_addr_b;
            iss_rem <= next_len;
            pop_rem <= next_len;
            if (tie) last_tie <= take_a ? CLIENT_A : CLIENT_B;
            if (next_len == '0) begin
              state   <= DONE;
              o_doneA <= take_a;
              o_doneB <= take_b;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            o_addr  <= o_addr + 1'b1;
            iss_rem <= iss_rem - 1'b1;
            if (iss_rem == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_rem == '0 || (pop_rem == LEN_W'(1) && pop)) begin
            state   <= DONE;
            o_doneA <= (grant == CLIENT_A);
            o_doneB <= (grant == CLIENT_B);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Credits count words issued but not yet handed to the client.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      credits <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (i_readData),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_data_streaming_sdram_read.sv
// Scoreboard bench for data_streaming_sdram_read: a behavioural SDRAM model
// returns a known word per address; expected per-client streams are queued
// when requests are issued and popped by an independent monitor.
module tb_data_streaming_sdram_read;

  logic        clk;
  logic        i_rst;
  logic        i_startA, i_startB;
  logic [18:0] i_addrA, i_addrB;
  logic [11:0] i_lenA, i_lenB;
  logic        o_busyA, o_busyB, o_doneA, o_doneB;
  logic [15:0] o_data;
  logic        o_validA, o_validB;
  logic        i_readyA, i_readyB;
  logic [18:0] o_addr;
  logic        o_enableRead;
  logic        i_sdramReady;
  logic [15:0] i_readData;
  logic        i_readValid;

  data_streaming_sdram_read dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_startA     (i_startA),
    .i_addrA      (i_addrA),
    .i_lenA       (i_lenA),
    .i_startB     (i_startB),
    .i_addrB      (i_addrB),
    .i_lenB       (i_lenB),
    .o_busyA      (o_busyA),
    .o_busyB      (o_busyB),
    .o_doneA      (o_doneA),
    .o_doneB      (o_doneB),
    .o_data       (o_data),
    .o_validA     (o_validA),
    .o_validB     (o_validB),
    .i_readyA     (i_readyA),
    .i_readyB     (i_readyB),
    .o_addr       (o_addr),
    .o_enableRead (o_enableRead),
    .i_sdramReady (i_sdramReady),
    .i_readData   (i_readData),
    .i_readValid  (i_readValid)
  );

  typedef struct {
    logic [18:0] addr;
    int          due;
  } ret_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  bit          done_exp_a = 0;
  bit          done_exp_b = 0;
  logic [18:0] cmd_log[$];
  ret_t        rq[$];
  int          rdy_a_mode = 1;
  int          rdy_b_mode = 1;
  int          sd_mode    = 1;
  bit          inject_stale = 0;
  int          pop_cnt_a = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Word the SDRAM model returns for a given address.
  function automatic logic [15:0] word_of(input logic [18:0] a);
    return a[15:0] ^ {a[18:16], 13'h1A5C};
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Queue the words a captured burst must deliver, in address order mod 2^19.
  task automatic expect_burst(input bit is_b, input logic [18:0] addr, input logic [11:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [18:0] a;
      a = 19'(addr + 19'(i));
      if (is_b) exp_b.push_back(word_of(a));
      else      exp_a.push_back(word_of(a));
    end
    if (is_b) done_exp_b = 1;
    else      done_exp_a = 1;
  endtask

  task automatic start_req(input bit is_b, input logic [18:0] addr, input logic [11:0] len);
    @(negedge clk);
    if (is_b) begin i_startB = 1; i_addrB = addr; i_lenB = len; end
    else      begin i_startA = 1; i_addrA = addr; i_lenA = len; end
    expect_burst(is_b, addr, len);
    @(negedge clk);
    i_startA = 0;
    i_startB = 0;
  endtask

  task automatic start_both(input logic [18:0] aa, input logic [11:0] la,
                            input logic [18:0] ab, input logic [11:0] lb);
    @(negedge clk);
    i_startA = 1; i_addrA = aa; i_lenA = la;
    i_startB = 1; i_addrB = ab; i_lenB = lb;
    expect_burst(0, aa, la);
    expect_burst(1, ab, lb);
    @(negedge clk);
    i_startA = 0;
    i_startB = 0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit ok = 0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      #3;
      if (!o_busyA && !o_busyB && exp_a.size() == 0 && exp_b.size() == 0 &&
          !done_exp_a && !done_exp_b) begin
        ok = 1;
        break;
      end
    end
    check({name, "_idle_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busyA"},  32'(o_busyA), 0);
    check({name, "_busyB"},  32'(o_busyB), 0);
    check({name, "_doneA"},  32'(o_doneA), 0);
    check({name, "_doneB"},  32'(o_doneB), 0);
    check({name, "_validA"}, 32'(o_validA), 0);
    check({name, "_validB"}, 32'(o_validB), 0);
    check({name, "_enable"}, 32'(o_enableRead), 0);
    check({name, "_addr"},   32'(o_addr), 0);
    check({name, "_data"},   32'(o_data), 0);
  endtask

  // SDRAM controller and client-ready model.
  initial begin
    i_sdramReady = 0; i_readValid = 0; i_readData = 0;
    i_readyA = 0; i_readyB = 0;
    forever begin
      @(negedge clk);
      i_readyA     = pick(rdy_a_mode);
      i_readyB     = pick(rdy_b_mode);
      i_sdramReady = pick(sd_mode);
      if (inject_stale) begin
        i_readValid  = 1;
        i_readData   = 16'hDEAD;
        inject_stale = 0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        i_readValid = 1;
        i_readData  = word_of(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        i_readValid = 0;
        i_readData  = 16'($urandom);
      end
      #1;
      if (i_rst) begin
        rq.delete();
        i_readValid = 0;
      end else if (o_enableRead && i_sdramReady) begin
        rq.push_back('{o_addr, cyc + 2});
        cmd_log.push_back(o_addr);
      end
    end
  end

  // Monitor: compares every delivered word and done pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!i_rst) begin
        check("valid_exclusive", 32'(o_validA && o_validB), 0);
        if (o_validA && i_readyA) begin
          check("a_word_expected", 32'(exp_a.size() != 0), 1);
          if (exp_a.size() != 0) check("a_data", 32'(o_data), 32'(exp_a.pop_front()));
          pop_cnt_a++;
        end
        if (o_validB && i_readyB) begin
          check("b_word_expected", 32'(exp_b.size() != 0), 1);
          if (exp_b.size() != 0) check("b_data", 32'(o_data), 32'(exp_b.pop_front()));
        end
        if (o_doneA) begin
          check("a_done_expected", 32'(done_exp_a), 1);
          check("a_done_all_delivered", 32'(exp_a.size()), 0);
          done_exp_a = 0;
        end
        if (o_doneB) begin
          check("b_done_expected", 32'(done_exp_b), 1);
          check("b_done_all_delivered", 32'(exp_b.size()), 0);
          done_exp_b = 0;
        end
      end
    end
  end

  initial begin
    logic [18:0] ra;
    i_rst = 1;
    i_startA = 0; i_startB = 0;
    i_addrA = 0; i_addrB = 0; i_lenA = 0; i_lenB = 0;
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk);
    i_rst = 0;
    #2 check_all_zero("post_reset");

    // Stale return while idle must be discarded.
    @(negedge clk);
    inject_stale = 1;
    repeat (4) @(negedge clk);

    // Basic burst on A with exact issue latency, plus an ignored start while busy.
    cmd_log.delete();
    start_req(0, 19'h00100, 12'd4);
    #2;
    check("a_busy_after_start", 32'(o_busyA), 1);
    check("a_no_issue_yet", 32'(o_enableRead), 0);
    @(negedge clk);
    #2;
    check("a_first_issue", 32'(o_enableRead), 1);
    check("a_first_addr", 32'(o_addr), 32'h100);
    @(negedge clk);
    i_startA = 1; i_addrA = 19'h55555; i_lenA = 12'd3;
    @(negedge clk);
    i_startA = 0;
    wait_idle("basic", 200);
    check("basic_cmd_count", 32'(cmd_log.size()), 4);
    for (int i = 0; i < 4; i++)
      if (cmd_log.size() > i) check($sformatf("basic_cmd%0d", i), 32'(cmd_log[i]), 32'h100 + 32'(i));

    // Backpressure: credits cap outstanding commands at the FIFO depth.
    cmd_log.delete();
    rdy_a_mode = 0;
    ra = 19'($urandom);
    start_req(0, ra, 12'd20);
    repeat (40) @(negedge clk);
    #2;
    check("bp_cmds_capped", 32'(cmd_log.size()), 8);
    check("bp_enable_stalled", 32'(o_enableRead), 0);
    rdy_a_mode = 2;
    wait_idle("bp", 500);
    check("bp_cmd_total", 32'(cmd_log.size()), 20);

    // Ties: A wins the first, B the next.
    rdy_a_mode = 1;
    cmd_log.delete();
    start_both(19'h00200, 12'd2, 19'h00300, 12'd2);
    wait_idle("tie1", 200);
    if (cmd_log.size() >= 4) begin
      check("tie1_first", 32'(cmd_log[0]), 32'h200);
      check("tie1_second", 32'(cmd_log[2]), 32'h300);
    end else check("tie1_cmd_count", 32'(cmd_log.size()), 4);
    cmd_log.delete();
    start_both(19'h00400, 12'd2, 19'h00500, 12'd2);
    wait_idle("tie2", 200);
    if (cmd_log.size() >= 4) begin
      check("tie2_first", 32'(cmd_log[0]), 32'h500);
      check("tie2_second", 32'(cmd_log[2]), 32'h400);
    end else check("tie2_cmd_count", 32'(cmd_log.size()), 4);

    // Address wrap at the top of the address space.
    cmd_log.delete();
    start_req(0, 19'h7FFFE, 12'd4);
    wait_idle("wrap", 200);
    check("wrap_cmd_count", 32'(cmd_log.size()), 4);
    if (cmd_log.size() >= 4) begin
      check("wrap_cmd0", 32'(cmd_log[0]), 32'h7FFFE);
      check("wrap_cmd1", 32'(cmd_log[1]), 32'h7FFFF);
      check("wrap_cmd2", 32'(cmd_log[2]), 32'h00000);
      check("wrap_cmd3", 32'(cmd_log[3]), 32'h00001);
    end

    // Zero-length burst on B: done two edges after the start is sampled.
    cmd_log.delete();
    start_req(1, 19'h01234, 12'd0);
    #2;
    check("len0_busy", 32'(o_busyB), 1);
    check("len0_done_early", 32'(o_doneB), 0);
    @(negedge clk);
    #2;
    check("len0_done", 32'(o_doneB), 1);
    @(negedge clk);
    #2;
    check("len0_done_once", 32'(o_doneB), 0);
    check("len0_busy_dropped", 32'(o_busyB), 0);
    check("len0_no_cmds", 32'(cmd_log.size()), 0);

    // Reset in the middle of a burst.
    pop_cnt_a = 0;
    start_req(0, 19'h02000, 12'd10);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #3;
      if (pop_cnt_a >= 3) break;
    end
    check("mid_reset_progress", 32'(pop_cnt_a >= 3), 1);
    i_rst = 1;
    exp_a.delete();
    done_exp_a = 0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    i_rst = 0;
    start_req(0, 19'h03000, 12'd5);
    wait_idle("after_reset", 200);

    // Randomized traffic on both clients with random readiness.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      rdy_a_mode = $urandom_range(0, 2);
      rdy_b_mode = $urandom_range(0, 2);
      sd_mode    = $urandom_range(1, 2);
      if (!o_busyA && $urandom_range(0, 2) == 0)
        start_req(0, 19'($urandom), 12'($urandom_range(0, 24)));
      if (!o_busyB && $urandom_range(0, 2) == 0)
        start_req(1, 19'($urandom), 12'($urandom_range(0, 24)));
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    rdy_a_mode = 2;
    rdy_b_mode = 2;
    sd_mode    = 2;
    wait_idle("random", 4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
